// File: rtl/serial_subtractor_pkg.sv
// Shared FSM encoding and sizing helper for the chunked serial subtractor.
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int cnt_width(input int nchunk);
      return (nchunk <= 1) ? 1 : $clog2(nchunk);
   endfunction

endpackage

// File: rtl/serial_subtractor_chunk.sv
// Combinational CHUNK-bit a + ~b + cin ripple of full adders.
module serial_subtractor_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout
);

   logic [CHUNK:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      logic bn;
      assign bn       = ~b[i];
      assign s[i]     = a[i] ^ bn ^ c[i];
      assign c[i + 1] = (a[i] & bn) | (a[i] & c[i]) | (bn & c[i]);
   end

   assign cout = c[CHUNK];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b, CHUNK bits per clock, valid/ready on both sides.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int N     = 32,
   parameter int CHUNK = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [N-1:0] diff,
   output logic         borrow,
   output logic         overflow,
   output logic         out_valid,
   input  logic         out_ready
);

   localparam int NCHUNK = N / CHUNK;
   localparam int CNT_W  = cnt_width(NCHUNK);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

   if ((CHUNK < 1) || (CHUNK > N) || (N % CHUNK != 0)) begin : g_bad_chunk
      $error("serial_subtractor: CHUNK must divide N and lie in 1..N");
   end

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             carry;
   logic [N-1:0]     a_sr;
   logic [N-1:0]     b_sr;
   logic             a_msb;
   logic             b_msb;
   logic [CHUNK-1:0] s;
   logic             c_out;
   logic [N-1:0]     diff_shift;

   serial_subtractor_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a    (a_sr[CHUNK-1:0]),
      .b    (b_sr[CHUNK-1:0]),
      .cin  (carry),
      .s    (s),
      .cout (c_out)
   );

   // New chunk enters at the top so the LSB chunk ends up at the bottom after NCHUNK shifts.
   assign diff_shift = (diff >> CHUNK) | (N'(s) << (N - CHUNK));
   assign in_ready   = (state == IDLE) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         carry     <= 1'b1;
         diff      <= '0;
         borrow    <= 1'b0;
         overflow  <= 1'b0;
         out_valid <= 1'b0;
         a_sr      <= '0;
         b_sr      <= '0;
         a_msb     <= 1'b0;
         b_msb     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  a_msb <= a[N-1];
                  b_msb <= b[N-1];
                  carry <= 1'b1;
                  cnt   <= '0;
                  state <= BUSY;
               end
            end
            BUSY: begin
               a_sr  <= a_sr >> CHUNK;
               b_sr  <= b_sr >> CHUNK;
               diff  <= diff_shift;
               carry <= c_out;
               cnt   <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  borrow    <= ~c_out;
                  // Sign bits were captured at accept because the shift registers are drained by now.
                  overflow  <= (a_msb != b_msb) && (s[CHUNK-1] != a_msb);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench: three subtractors (CHUNK 1, 4, 32) against an arithmetic reference model.
module tb_serial_subtractor;

   typedef struct {
      logic [31:0] d;
      logic        bo;
      logic        ov;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst       [3];
   logic [31:0] a         [3];
   logic [31:0] b         [3];
   logic        in_valid  [3];
   logic        in_ready  [3];
   logic [31:0] diff      [3];
   logic        borrow    [3];
   logic        overflow  [3];
   logic        out_valid [3];
   logic        out_ready [3];

   exp_t q [3][$];
   bit   seen [3];
   bit   hold [3];
   int   cyc   = 0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      serial_subtractor #(.N(32), .CHUNK(g == 0 ? 1 : (g == 1 ? 4 : 32))) dut (
         .clk       (clk),
         .rst       (rst[g]),
         .a         (a[g]),
         .b         (b[g]),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .diff      (diff[g]),
         .borrow    (borrow[g]),
         .overflow  (overflow[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g])
      );
   end

   function automatic int chunk_of(input int l);
      return (l == 0) ? 1 : ((l == 1) ? 4 : 32);
   endfunction

   task automatic chk(input string nm, input int l, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s lane%0d actual=%h required=%h", nm, l, act, req);
      end
   endtask

   // Reference model: plain integer subtraction with signed range test.
   function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv, input int acc);
      exp_t   e;
      longint sd;
      sd    = longint'($signed(av)) - longint'($signed(bv));
      e.d   = av - bv;
      e.bo  = (av < bv);
      e.ov  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
      e.acc = acc;
      return e;
   endfunction

   task automatic send(input int l, input logic [31:0] av, input logic [31:0] bv);
      int to = 0;
      @(negedge clk);
      a[l]        = av;
      b[l]        = bv;
      in_valid[l] = 1'b1;
      while (!in_ready[l] && to < 500) begin
         @(negedge clk);
         to++;
      end
      chk("accept_timeout", l, 32'(to >= 500), 32'd0);
      q[l].push_back(model(av, bv, cyc + 1));
      @(negedge clk);
      in_valid[l] = 1'b0;
      a[l]        = $urandom;
      b[l]        = $urandom;
   endtask

   task automatic drain(input int l);
      int to = 0;
      while (q[l].size() != 0 && to < 2000) begin
         @(negedge clk);
         to++;
      end
      chk("drain_timeout", l, 32'(to >= 2000), 32'd0);
   endtask

   function automatic logic [31:0] rand_op();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic run_rand(input int l);
      for (int i = 0; i < 1000; i++) send(l, rand_op(), rand_op());
      drain(l);
   endtask

   // Monitor: owns out_ready, checks latency on the rising out_valid and values on each handshake.
   always @(negedge clk) begin
      for (int l = 0; l < 3; l++) begin
         if (out_valid[l] && !seen[l]) begin
            seen[l] = 1'b1;
            if (q[l].size() == 0) chk("unexpected_out", l, 32'd1, 32'd0);
            else chk("latency", l, 32'(cyc - q[l][0].acc), 32'(32 / chunk_of(l)));
         end
         out_ready[l] = !hold[l] && ($urandom_range(0, 3) != 0);
         if (out_valid[l] && out_ready[l] && q[l].size() != 0) begin
            exp_t e;
            e = q[l].pop_front();
            chk("diff", l, diff[l], e.d);
            chk("borrow", l, 32'(borrow[l]), 32'(e.bo));
            chk("overflow", l, 32'(overflow[l]), 32'(e.ov));
            seen[l] = 1'b0;
         end
      end
   end

   initial begin
      int to;
      for (int l = 0; l < 3; l++) begin
         rst[l] = 1'b1; in_valid[l] = 1'b0; a[l] = '0; b[l] = '0;
         hold[l] = 1'b0; seen[l] = 1'b0; out_ready[l] = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int l = 0; l < 3; l++) begin
         chk("rst_out_valid", l, 32'(out_valid[l]), 32'd0);
         chk("rst_diff", l, diff[l], 32'd0);
         chk("rst_borrow", l, 32'(borrow[l]), 32'd0);
         chk("rst_overflow", l, 32'(overflow[l]), 32'd0);
         chk("rst_in_ready", l, 32'(in_ready[l]), 32'd0);
         rst[l] = 1'b0;
      end
      #1;
      for (int l = 0; l < 3; l++) chk("idle_in_ready", l, 32'(in_ready[l]), 32'd1);

      // Directed cases on the CHUNK=4 lane.
      send(1, 32'd1000, 32'd1000);
      send(1, 32'd3000, 32'd5000);
      send(1, 32'h8000_0000, 32'd1);
      drain(1);

      hold[1] = 1'b1;
      send(1, 32'd7000, 32'd2000);
      to = 0;
      while (!out_valid[1] && to < 100) begin
         @(negedge clk);
         to++;
      end
      chk("stall_wait", 1, 32'(to >= 100), 32'd0);
      for (int i = 0; i < 20; i++) begin
         chk("stall_valid", 1, 32'(out_valid[1]), 32'd1);
         chk("stall_diff", 1, diff[1], 32'd5000);
         chk("stall_borrow", 1, 32'(borrow[1]), 32'd0);
         chk("stall_in_ready", 1, 32'(in_ready[1]), 32'd0);
         in_valid[1] = (i == 5);
         a[1] = 32'd123456;
         b[1] = 32'd654;
         @(negedge clk);
      end
      in_valid[1] = 1'b0;
      hold[1] = 1'b0;
      drain(1);
      send(1, 32'd9, 32'd4);
      drain(1);

      send(1, 32'd11111, 32'd22222);
      repeat (2) @(negedge clk);
      rst[1] = 1'b1;
      @(negedge clk);
      chk("midrst_out_valid", 1, 32'(out_valid[1]), 32'd0);
      chk("midrst_diff", 1, diff[1], 32'd0);
      rst[1] = 1'b0;
      q[1].delete();
      seen[1] = 1'b0;
      #1;
      chk("midrst_in_ready", 1, 32'(in_ready[1]), 32'd1);
      send(1, 32'd8000, 32'd4000);
      drain(1);

      fork
         run_rand(0);
         run_rand(1);
         run_rand(2);
      join

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #(2_000_000);
      fails++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
